// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared widths, 8N1 constants and FSM encodings for the UART SoC slice
package soc_pkg;

   // 8N1 framing: one start bit, eight data bits, one stop bit
   localparam int DATA_BITS = 8;
   localparam int BIT_IDX_W = 3;
   localparam int CNT_W     = 16;
   localparam int STATE_W   = 3;

   localparam logic [BIT_IDX_W-1:0] LAST_BIT = 3'(DATA_BITS - 1);

   typedef logic [STATE_W-1:0] tx_state_t;
   typedef logic [STATE_W-1:0] rx_state_t;

   // TX engine states
   localparam tx_state_t TX_IDLE  = 3'd0;
   localparam tx_state_t TX_START = 3'd1;
   localparam tx_state_t TX_DATA  = 3'd2;
   localparam tx_state_t TX_STOP  = 3'd3;
   localparam tx_state_t TX_DONE  = 3'd4;

   // RX engine states; RX_WAIT blocks start detection after a framing error
   localparam rx_state_t RX_IDLE  = 3'd0;
   localparam rx_state_t RX_START = 3'd1;
   localparam rx_state_t RX_DATA  = 3'd2;
   localparam rx_state_t RX_STOP  = 3'd3;
   localparam rx_state_t RX_WAIT  = 3'd4;

endpackage

// File: rtl/soc_uart.sv
// rtl/soc_uart.sv - 8N1 UART TX and RX engines with per-frame latched baud divider
module soc_uart
   import soc_pkg::*;
#(
   parameter int DIV_WID = 4
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_WID-1:0]   div_factor,
   input  logic [DATA_BITS-1:0] tx_tdata,
   input  logic                 tx_tvalid,
   input  logic                 tx_tlast,
   output logic                 tx_tready,
   output logic                 txd
`ifdef SOC_UART_RX_EN
   ,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_tdata,
   output logic                 rx_tvalid,
   output logic                 rx_err
`endif
);

   tx_state_t            tx_state;
   logic [DIV_WID-1:0]   tx_div;
   logic [DIV_WID-1:0]   tx_cnt;
   logic [BIT_IDX_W-1:0] tx_bit;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_last;
   logic                 tx_bit_end;
   logic                 tx_accept;

   assign tx_bit_end = (tx_cnt == tx_div);
   // A new byte is taken either from idle or exactly at the end of a stop bit,
   // which keeps consecutive frames gap-free.
   assign tx_tready  = (tx_state == TX_IDLE) ||
                       ((tx_state == TX_STOP) && tx_bit_end && !tx_last);
   assign tx_accept  = tx_tready && tx_tvalid;

   // TX frame sequencing: start, 8 data bits LSB first, stop, then next byte or DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_div   <= '0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_last  <= 1'b0;
         txd      <= 1'b1;
      end else if (tx_accept) begin
         tx_state <= TX_START;
         tx_div   <= div_factor;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= tx_tdata;
         tx_last  <= tx_tlast;
         txd      <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               txd <= 1'b1;
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_state <= TX_DATA;
                  txd      <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt + DIV_WID'(1);
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (tx_bit == LAST_BIT) begin
                     tx_state <= TX_STOP;
                     txd      <= 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + BIT_IDX_W'(1);
                     tx_shift <= tx_shift >> 1;
                     txd      <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + DIV_WID'(1);
               end
            end
            TX_STOP: begin
               txd <= 1'b1;
               if (tx_bit_end) begin
                  tx_cnt   <= '0;
                  tx_state <= tx_last ? TX_DONE : TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + DIV_WID'(1);
               end
            end
            TX_DONE: begin
               txd <= 1'b1;
            end
            default: begin
               tx_state <= TX_IDLE;
               txd      <= 1'b1;
            end
         endcase
      end
   end

`ifdef SOC_UART_RX_EN
   logic                 sync1;
   logic                 sync2;
   logic                 rx_prev;
   rx_state_t            rx_state;
   logic [DIV_WID-1:0]   rx_div;
   logic [DIV_WID-1:0]   rx_cnt;
   logic [DIV_WID:0]     rx_half;
   logic [BIT_IDX_W-1:0] rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_hit;
   logic                 rx_bit_end;

   // Sample point (div+1)/2 always lands before or on the last count of the bit
   assign rx_half    = ({1'b0, rx_div} + (DIV_WID+1)'(1)) >> 1;
   assign rx_hit     = ({1'b0, rx_cnt} == rx_half);
   assign rx_bit_end = (rx_cnt == rx_div);
   assign rx_tdata   = rx_shift;

   // Two-flop synchronizer, idle-high so reset does not look like a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rxd;
         sync2 <= sync1;
      end
   end

   // RX frame capture: falling-edge start, mid-bit sampling, stop-bit validation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state  <= RX_IDLE;
         rx_prev   <= 1'b1;
         rx_div    <= '0;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         rx_tvalid <= 1'b0;
         rx_err    <= 1'b0;
      end else begin
         rx_prev   <= sync2;
         rx_tvalid <= 1'b0;
         rx_err    <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !sync2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
                  rx_div   <= div_factor;
               end
            end
            RX_START: begin
               if (rx_hit && sync2) begin
                  rx_state <= RX_IDLE;
               end else if (rx_bit_end) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + DIV_WID'(1);
               end
            end
            RX_DATA: begin
               if (rx_hit) begin
                  rx_shift <= {sync2, rx_shift[DATA_BITS-1:1]};
               end
               if (rx_bit_end) begin
                  rx_cnt <= '0;
                  if (rx_bit == LAST_BIT) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_bit <= rx_bit + BIT_IDX_W'(1);
                  end
               end else begin
                  rx_cnt <= rx_cnt + DIV_WID'(1);
               end
            end
            RX_STOP: begin
               if (rx_hit) begin
                  if (sync2) begin
                     rx_tvalid <= 1'b1;
                     rx_state  <= RX_IDLE;
                  end else begin
                     rx_err   <= 1'b1;
                     rx_state <= RX_WAIT;
                  end
               end else begin
                  rx_cnt <= rx_cnt + DIV_WID'(1);
               end
            end
            RX_WAIT: begin
               if (sync2) begin
                  rx_state <= RX_IDLE;
               end
            end
            default: begin
               rx_state <= RX_IDLE;
            end
         endcase
      end
   end
`endif

endmodule

// File: rtl/soc_top.sv
// rtl/soc_top.sv - UART SoC top: ITCM message ROM, TX sequencer, optional RX/DTCM (SOC_UART_RX_EN)
module soc_top
   import soc_pkg::*;
#(
   parameter int HCLK_PERIOD  = 10,
   parameter int DIV_WID      = 4,
   parameter int HADDR_WIDTH  = 32,
   parameter int PADDR_WIDTH  = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int ITCM_DEEPTH  = 64,
   parameter int DTCM_DEEPTH  = 64,
   parameter int PSLV_NUM     = 5,
   parameter int HSLV_NUM     = 5,
   parameter int HMAS_NUM     = 5,
   parameter int PSLV_LEN     = 32,
   parameter int HSLV_LEN     = 32,
   parameter int HMAS_LEN     = 32,
   parameter int HBURST_WIDTH = 3,
   parameter int IRQ_LEN      = 16
)
(
   input  logic               hclk,
   input  logic               hresetn,
   input  logic [DIV_WID-1:0] div_factor,
   output logic               uart_txd,
   input  logic               uart_rxd
);

   localparam int ITCM_AW = (ITCM_DEEPTH > 1) ? $clog2(ITCM_DEEPTH) : 1;

   logic [DATA_WIDTH-1:0] itcm_mem [ITCM_DEEPTH];
   logic [DATA_WIDTH-1:0] tx_word;
   logic [ITCM_AW-1:0]    rd_ptr;
   logic                  seq_done;
   logic                  tx_tvalid;
   logic                  tx_tready;
   logic                  tx_tlast;
   logic                  unused_top;

   // ITCM contents are fixed: word i holds the value i
   always_comb begin
      for (int i = 0; i < ITCM_DEEPTH; i++) begin
         itcm_mem[i] = DATA_WIDTH'(i);
      end
   end

   assign tx_word   = itcm_mem[rd_ptr];
   assign tx_tvalid = !seq_done;
   assign tx_tlast  = (rd_ptr == ITCM_AW'(ITCM_DEEPTH - 1));

   // Sequencer walks the ITCM once; the last handshake retires the stream
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         rd_ptr   <= '0;
         seq_done <= 1'b0;
      end else if (tx_tvalid && tx_tready) begin
         if (tx_tlast) begin
            seq_done <= 1'b1;
         end else begin
            rd_ptr <= rd_ptr + ITCM_AW'(1);
         end
      end
   end

`ifdef SOC_UART_RX_EN
   localparam int DTCM_AW = (DTCM_DEEPTH > 1) ? $clog2(DTCM_DEEPTH) : 1;

   logic [DATA_WIDTH-1:0] dtcm_mem [DTCM_DEEPTH];
   logic [DTCM_AW-1:0]    wr_ptr;
   logic [CNT_W-1:0]      rx_count;
   logic [CNT_W-1:0]      rx_err_count;
   logic [DATA_BITS-1:0]  rx_tdata;
   logic                  rx_tvalid;
   logic                  rx_err;

   soc_uart #(.DIV_WID(DIV_WID)) u_uart (
      .clk        (hclk),
      .rst_n      (hresetn),
      .div_factor (div_factor),
      .tx_tdata   (tx_word[DATA_BITS-1:0]),
      .tx_tvalid  (tx_tvalid),
      .tx_tlast   (tx_tlast),
      .tx_tready  (tx_tready),
      .txd        (uart_txd),
      .rxd        (uart_rxd),
      .rx_tdata   (rx_tdata),
      .rx_tvalid  (rx_tvalid),
      .rx_err     (rx_err)
   );

   // DTCM capture write; contents survive reset
   always_ff @(posedge hclk) begin
      if (rx_tvalid) begin
         dtcm_mem[wr_ptr] <= DATA_WIDTH'(rx_tdata);
      end
   end

   // Write pointer wraps, both counters saturate
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         wr_ptr       <= '0;
         rx_count     <= '0;
         rx_err_count <= '0;
      end else begin
         if (rx_tvalid) begin
            wr_ptr <= (wr_ptr == DTCM_AW'(DTCM_DEEPTH - 1)) ? '0 : wr_ptr + DTCM_AW'(1);
            if (rx_count != '1) begin
               rx_count <= rx_count + CNT_W'(1);
            end
         end
         if (rx_err && (rx_err_count != '1)) begin
            rx_err_count <= rx_err_count + CNT_W'(1);
         end
      end
   end

   assign unused_top = ^{tx_word, rx_count, rx_err_count, dtcm_mem[0],
                         32'(HCLK_PERIOD), 32'(HADDR_WIDTH), 32'(PADDR_WIDTH),
                         32'(PSLV_NUM), 32'(HSLV_NUM), 32'(HMAS_NUM),
                         32'(PSLV_LEN), 32'(HSLV_LEN), 32'(HMAS_LEN),
                         32'(HBURST_WIDTH), 32'(IRQ_LEN)};
`else
   soc_uart #(.DIV_WID(DIV_WID)) u_uart (
      .clk        (hclk),
      .rst_n      (hresetn),
      .div_factor (div_factor),
      .tx_tdata   (tx_word[DATA_BITS-1:0]),
      .tx_tvalid  (tx_tvalid),
      .tx_tlast   (tx_tlast),
      .tx_tready  (tx_tready),
      .txd        (uart_txd)
   );

   assign unused_top = ^{tx_word, uart_rxd, 32'(DTCM_DEEPTH),
                         32'(HCLK_PERIOD), 32'(HADDR_WIDTH), 32'(PADDR_WIDTH),
                         32'(PSLV_NUM), 32'(HSLV_NUM), 32'(HMAS_NUM),
                         32'(PSLV_LEN), 32'(HSLV_LEN), 32'(HMAS_LEN),
                         32'(HBURST_WIDTH), 32'(IRQ_LEN)};
`endif

endmodule

// File: tb/tb_soc_top.sv
// tb/tb_soc_top.sv - self-checking bench for soc_top UART TX stream, DONE state, reset and optional RX
module tb_soc_top;
   import soc_pkg::*;

   logic       hclk;
   logic       hresetn;
   logic [3:0] div_factor;
   logic       uart_txd;
   logic       uart_rxd;

   logic       rst4;
   logic [3:0] div4;
   logic       txd4;
   logic       rxd4;

   int tests_run;
   int tests_failed;

   logic [7:0] exp_q [$];

   soc_top dut (
      .hclk       (hclk),
      .hresetn    (hresetn),
      .div_factor (div_factor),
      .uart_txd   (uart_txd),
      .uart_rxd   (uart_rxd)
   );

   soc_top #(.ITCM_DEEPTH(4)) dut4 (
      .hclk       (hclk),
      .hresetn    (rst4),
      .div_factor (div4),
      .uart_txd   (txd4),
      .uart_rxd   (rxd4)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Capture one frame of per-cycle bits; each bit window must be constant
   task automatic get_frame(input int per, input bit use4,
                            output logic [7:0] data, output bit shape_ok);
      logic lvl;
      logic line;
      shape_ok = 1'b1;
      data     = 8'h00;
      lvl      = 1'b1;
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < per; c++) begin
            @(negedge hclk);
            line = use4 ? txd4 : uart_txd;
            if (c == 0) lvl = line;
            else if (line !== lvl) shape_ok = 1'b0;
         end
         if (b == 0 && lvl !== 1'b0) shape_ok = 1'b0;
         if (b == 9 && lvl !== 1'b1) shape_ok = 1'b0;
         if (b >= 1 && b <= 8) data[b-1] = lvl;
      end
   endtask

   task automatic test_reset;
      hresetn    = 1'b0;
      rst4       = 1'b0;
      div_factor = 4'd10;
      div4       = 4'd0;
      uart_rxd   = 1'b1;
      rxd4       = 1'b1;
      repeat (5) @(negedge hclk);
      tests_run++;
      if (uart_txd !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_txd: got %b want 1", uart_txd);
      end
      tests_run++;
      if (txd4 !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_txd4: got %b want 1", txd4);
      end
   endtask

   task automatic test_first_frames;
      logic [7:0] got;
      logic [7:0] want;
      bit ok;
      for (int i = 0; i < 27; i++) exp_q.push_back(8'(i));
      hresetn = 1'b1;
      for (int f = 0; f < 2; f++) begin
         get_frame(11, 1'b0, got, ok);
         want = exp_q.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL first_frame_data[%0d]: got %02h want %02h", f, got, want);
         end
         tests_run++;
         if (!ok) begin
            tests_failed++;
            $display("FAIL first_frame_shape[%0d]: got bad bit timing want 11-cycle 8N1 bits", f);
         end
      end
   endtask

   task automatic test_stream;
      logic [7:0] got;
      logic [7:0] want;
      bit ok;
      for (int f = 2; f < 27; f++) begin
         get_frame(11, 1'b0, got, ok);
         want = exp_q.pop_front();
         tests_run++;
         if (got !== want || !ok) begin
            tests_failed++;
            $display("FAIL stream_frame[%0d]: got %02h shape_ok=%0d want %02h shape_ok=1", f, got, ok, want);
         end
      end
      @(negedge hclk);
      tests_run++;
      if (uart_txd !== 1'b0) begin
         tests_failed++;
         $display("FAIL stream_no_gap: got txd=%b want 0 (next start bit)", uart_txd);
      end
   endtask

   task automatic test_mid_reset;
      logic [7:0] got;
      logic [7:0] want;
      bit ok;
      int bad;
      hresetn = 1'b0;
      repeat (3) @(negedge hclk);
      hresetn = 1'b1;
      repeat (500) @(negedge hclk);
      hresetn = 1'b0;
      #1;
      bad = (uart_txd !== 1'b1) ? 1 : 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge hclk);
         if (uart_txd !== 1'b1) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL mid_reset_txd: got %0d low samples want 0", bad);
      end
      exp_q.push_back(8'h00);
      hresetn = 1'b1;
      get_frame(11, 1'b0, got, ok);
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want || !ok) begin
         tests_failed++;
         $display("FAIL mid_reset_restart: got %02h shape_ok=%0d want %02h shape_ok=1", got, ok, want);
      end
   endtask

   task automatic test_done;
      logic [7:0] got;
      logic [7:0] want;
      bit ok;
      int bad;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
      @(negedge hclk);
      rst4 = 1'b1;
      for (int f = 0; f < 4; f++) begin
         get_frame(1, 1'b1, got, ok);
         want = exp_q.pop_front();
         tests_run++;
         if (got !== want || !ok) begin
            tests_failed++;
            $display("FAIL done_frame[%0d]: got %02h shape_ok=%0d want %02h shape_ok=1", f, got, ok, want);
         end
      end
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge hclk);
         if (txd4 !== 1'b1) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL done_hold_high: got %0d low samples want 0", bad);
      end
      tests_run++;
      if (dut4.u_uart.tx_state !== TX_DONE) begin
         tests_failed++;
         $display("FAIL done_state: got %0d want %0d", dut4.u_uart.tx_state, TX_DONE);
      end
   endtask

`ifdef SOC_UART_RX_EN
   task automatic send_byte(input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = frame[i];
         repeat (11) @(negedge hclk);
      end
   endtask

   task automatic test_rx_bytes;
      logic [7:0] want;
      int budget;
      hresetn  = 1'b0;
      uart_rxd = 1'b1;
      repeat (3) @(negedge hclk);
      hresetn = 1'b1;
      repeat (5) @(negedge hclk);
      exp_q.push_back(8'hA5);
      send_byte(8'hA5);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C);
      budget = 0;
      while (dut.rx_count < 16'd2 && budget < 40) begin
         @(negedge hclk);
         budget++;
      end
      tests_run++;
      if (dut.rx_count !== 16'd2) begin
         tests_failed++;
         $display("FAIL rx_count: got %0d want 2", dut.rx_count);
      end
      for (int i = 0; i < 2; i++) begin
         want = exp_q.pop_front();
         tests_run++;
         if (dut.dtcm_mem[i] !== {24'h0, want}) begin
            tests_failed++;
            $display("FAIL rx_dtcm[%0d]: got %08h want %08h", i, dut.dtcm_mem[i], {24'h0, want});
         end
      end
      tests_run++;
      if (dut.rx_err_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL rx_err_none: got %0d want 0", dut.rx_err_count);
      end
   endtask

   task automatic test_rx_framing;
      int budget;
      hresetn  = 1'b0;
      uart_rxd = 1'b0;
      repeat (3) @(negedge hclk);
      hresetn = 1'b1;
      repeat (400) @(negedge hclk);
      tests_run++;
      if (dut.rx_err_count !== 16'd1 || dut.rx_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL rx_framing: got err=%0d cnt=%0d want err=1 cnt=0", dut.rx_err_count, dut.rx_count);
      end
      uart_rxd = 1'b1;
      repeat (30) @(negedge hclk);
      exp_q.push_back(8'h5A);
      send_byte(8'h5A);
      budget = 0;
      while (dut.rx_count < 16'd1 && budget < 40) begin
         @(negedge hclk);
         budget++;
      end
      tests_run++;
      if (dut.rx_count !== 16'd1 || dut.rx_err_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL rx_resume: got cnt=%0d err=%0d want cnt=1 err=1", dut.rx_count, dut.rx_err_count);
      end
      tests_run++;
      if (dut.dtcm_mem[0] !== {24'h0, exp_q[0]}) begin
         tests_failed++;
         $display("FAIL rx_resume_data: got %08h want %08h", dut.dtcm_mem[0], {24'h0, exp_q[0]});
      end
      void'(exp_q.pop_front());
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_first_frames();
      test_stream();
      test_mid_reset();
      test_done();
`ifdef SOC_UART_RX_EN
      test_rx_bytes();
      test_rx_framing();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
